// File: rtl/rom_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rom_pkg : shared widths, RAM mode and FSM state for the ROM reader |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
package rom_pkg;

  localparam int ROM_ADDR_W       = 8;
  localparam int RAM_RADDR_W      = 11;
  localparam int ROM_DATA_W       = 16;
  localparam int READ_MODE_256X16 = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_skid_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rom_skid_fifo : 2-entry FIFO absorbing RAM read latency           |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
module rom_skid_fifo #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [1:0]            o_count,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (i_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rom_stream_reader : sequential RAM reads turned into a stream     |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
module rom_stream_reader
  import rom_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDR_W,
  parameter int DATA_WIDTH = ROM_DATA_W
) (
  input  logic                   CLKIN,
  input  logic                   RESETN,
  input  logic                   START,
  input  logic [ADDR_WIDTH-1:0]  BASE,
  input  logic [ADDR_WIDTH:0]    COUNT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [RAM_RADDR_W-1:0] RADDR,
  output logic                   RE,
  input  logic [DATA_WIDTH-1:0]  RDATA,
  output logic [DATA_WIDTH-1:0]  DOUT,
  output logic                   DVALID,
  input  logic                   DREADY
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
  logic [ADDR_WIDTH:0]   accept_left_q, accept_left_d;
  logic                  inflight_q, inflight_d;
  logic                  zero_done_q, zero_done_d;

  logic [1:0] w_fifo_count;
  logic [2:0] w_occ;
  logic       w_pop;
  logic       w_issue;
  logic       w_last_pop;

  always_comb begin
    w_pop      = (w_fifo_count != 2'd0) && DREADY;
    // Words already committed: queued in the FIFO plus the read in flight.
    w_occ      = {1'b0, w_fifo_count} + {2'b00, inflight_q};
    w_issue    = (state_q == RUN) && (issue_left_q != '0) &&
                 ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));
    w_last_pop = (state_q == DRAIN) && w_pop && (accept_left_q == CNT_ONE);

    state_d       = state_q;
    addr_d        = addr_q;
    issue_left_d  = issue_left_q;
    accept_left_d = accept_left_q;
    inflight_d    = w_issue;
    zero_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            addr_d        = BASE;
            issue_left_d  = COUNT;
            accept_left_d = COUNT;
            state_d       = RUN;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_issue) begin
          addr_d       = addr_q + ADDR_ONE;
          issue_left_d = issue_left_q - CNT_ONE;
          if (issue_left_q == CNT_ONE) begin
            state_d = DRAIN;
          end
        end
        if (w_pop) begin
          accept_left_d = accept_left_q - CNT_ONE;
        end
      end
      DRAIN: begin
        if (w_pop) begin
          accept_left_d = accept_left_q - CNT_ONE;
        end
        if (w_last_pop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      issue_left_q  <= '0;
      accept_left_q <= '0;
      inflight_q    <= 1'b0;
      zero_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      issue_left_q  <= issue_left_d;
      accept_left_q <= accept_left_d;
      inflight_q    <= inflight_d;
      zero_done_q   <= zero_done_d;
    end
  end

  rom_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (CLKIN),
    .rst_n       (RESETN),
    .i_push      (inflight_q),
    .i_push_data (RDATA),
    .i_pop       (w_pop),
    .o_count     (w_fifo_count),
    .o_head      (DOUT)
  );

  assign BUSY   = (state_q != IDLE);
  assign DONE   = zero_done_q || w_last_pop;
  assign RE     = w_issue;
  assign RADDR  = {{(RAM_RADDR_W-ADDR_WIDTH){1'b0}}, addr_q};
  assign DVALID = (w_fifo_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_rom_stream_reader : directed bench with a behavioural RAM     |
// | Revision: 1.0                                                     |
// +-----------------------------------------------------------------+
module tb_rom_stream_reader;

  logic        CLKIN;
  logic        RESETN;
  logic        START;
  logic [7:0]  BASE;
  logic [8:0]  COUNT;
  logic        BUSY;
  logic        DONE;
  logic [10:0] RADDR;
  logic        RE;
  logic [15:0] RDATA;
  logic [15:0] DOUT;
  logic        DVALID;
  logic        DREADY;

  logic [15:0] rom [256];

  int n_checks;
  int n_errors;

  typedef struct {
    logic        start;
    logic [7:0]  base;
    logic [8:0]  count;
    logic        dready;
    logic [3:0]  exp_flags;   // {BUSY, DONE, RE, DVALID}
    logic        chk_raddr;
    logic [10:0] exp_raddr;
    logic        chk_dout;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [8];

  rom_stream_reader #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16)
  ) dut (
    .CLKIN  (CLKIN),
    .RESETN (RESETN),
    .START  (START),
    .BASE   (BASE),
    .COUNT  (COUNT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RADDR  (RADDR),
    .RE     (RE),
    .RDATA  (RDATA),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .DREADY (DREADY)
  );

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  // Registered-output RAM read port.
  initial RDATA = 16'h0000;
  always @(posedge CLKIN) begin
    if (RE) RDATA <= rom[RADDR[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [31:0] act;
    act = {2'b00, BUSY, DONE, RE, DVALID, RADDR, DOUT};
    check(name, act, 32'h0);
  endtask

  task automatic run_job(input logic [7:0] base, input logic [8:0] count,
                         input bit rnd, input int extra_start);
    int          re_n;
    int          acc;
    int          cyc;
    bit          done_seen;
    logic        stalled;
    logic [15:0] held;
    logic [7:0]  a;
    re_n = 0; acc = 0; done_seen = 1'b0; stalled = 1'b0; held = 16'h0;
    for (cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      START  = (cyc == 0) || (cyc == extra_start);
      BASE   = (cyc == 0) ? base : 8'h80;
      COUNT  = (cyc == 0) ? count : 9'd3;
      DREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        check("stall_dvalid", {31'd0, DVALID}, 32'd1);
        check("stall_dout", {16'd0, DOUT}, {16'd0, held});
      end
      if (DVALID && DREADY) begin
        a = base + 8'(acc);
        check("dout", {16'd0, DOUT}, {16'd0, rom[a]});
        acc++;
      end
      if (RE) begin
        a = base + 8'(re_n);
        check("raddr", {21'd0, RADDR}, {24'd0, a});
        re_n++;
        check("outstanding_le_2", {31'd0, (re_n - acc) <= 2}, 32'd1);
      end
      stalled = DVALID && !DREADY;
      held    = DOUT;
      if (DONE) begin
        done_seen = 1'b1;
        check("done_word_count", acc, {23'd0, count});
        if (!rnd) check("done_cycle", cyc, {23'd0, count} + 32'd2);
      end
      @(negedge CLKIN);
    end
    START = 1'b0;
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    check("re_count", re_n, {23'd0, count});
    DREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("post_job_quiet", {28'd0, BUSY, DONE, RE, DVALID}, 32'd0);
      @(negedge CLKIN);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'(i * 257);
    rom[16] = 16'hA5A5;

    //            start base   count  rdy   BDRV     chkA  raddr    chkD  dout
    vecs[0] = '{1'b1, 8'h10, 9'd1, 1'b1, 4'b0000, 1'b0, 11'h000, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 8'h00, 9'd0, 1'b1, 4'b1010, 1'b1, 11'h010, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 8'h00, 9'd0, 1'b1, 4'b1000, 1'b0, 11'h000, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 8'h00, 9'd0, 1'b1, 4'b1101, 1'b0, 11'h000, 1'b1, 16'hA5A5};
    vecs[4] = '{1'b0, 8'h00, 9'd0, 1'b1, 4'b0000, 1'b0, 11'h000, 1'b0, 16'h0000};
    vecs[5] = '{1'b1, 8'h55, 9'd0, 1'b1, 4'b0000, 1'b0, 11'h000, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 8'h00, 9'd0, 1'b1, 4'b0100, 1'b0, 11'h000, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 8'h00, 9'd0, 1'b1, 4'b0000, 1'b0, 11'h000, 1'b0, 16'h0000};

    RESETN = 1'b0; START = 1'b0; BASE = 8'h00; COUNT = 9'd0; DREADY = 1'b0;
    @(negedge CLKIN);
    @(negedge CLKIN);
    #1;
    check_reset_outputs("reset_values");
    @(negedge CLKIN);
    RESETN = 1'b1;
    @(negedge CLKIN);

    // Single word and zero-length job.
    for (int i = 0; i < 8; i++) begin
      START  = vecs[i].start;
      BASE   = vecs[i].base;
      COUNT  = vecs[i].count;
      DREADY = vecs[i].dready;
      #1;
      check($sformatf("vec%0d_flags", i), {28'd0, BUSY, DONE, RE, DVALID},
            {28'd0, vecs[i].exp_flags});
      if (vecs[i].chk_raddr)
        check($sformatf("vec%0d_raddr", i), {21'd0, RADDR}, {21'd0, vecs[i].exp_raddr});
      if (vecs[i].chk_dout)
        check($sformatf("vec%0d_dout", i), {16'd0, DOUT}, {16'd0, vecs[i].exp_dout});
      @(negedge CLKIN);
    end
    START = 1'b0;

    run_job(8'h00, 9'd16, 1'b0, -1);   // streaming
    run_job(8'hFE, 9'd4,  1'b0, -1);   // address wrap
    run_job(8'h30, 9'd8,  1'b1, -1);   // random backpressure
    run_job(8'h20, 9'd8,  1'b0, 3);    // START while busy
    run_job(8'hC0, 9'd12, 1'b1, 5);    // START while busy under backpressure

    // Reset in cycle 5 of a 20-word job.
    START = 1'b1; BASE = 8'h00; COUNT = 9'd20; DREADY = 1'b1;
    @(negedge CLKIN);
    START = 1'b0;
    for (int k = 1; k < 5; k++) @(negedge CLKIN);
    RESETN = 1'b0;
    #1;
    check_reset_outputs("midjob_reset_values");
    @(negedge CLKIN);
    #1;
    check_reset_outputs("midjob_reset_hold");
    @(negedge CLKIN);
    RESETN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("after_reset_quiet", {29'd0, BUSY, DONE, DVALID}, 32'd0);
      @(negedge CLKIN);
    end
    run_job(8'h40, 9'd2, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
